mask_centroid: RTL and testbench
================================

Name: mask_centroid

Overview:
- Downstream consumer of the skin/object decision stage.
- Takes the 1-bit per-pixel object mask in raster order and accumulates pixel count, coordinate sums and bounding box per 160x120 frame.
- At end of frame, divides sums by count to produce the object centroid and presents one result per frame on a valid/ready handshake to the gesture classifier.

Parameters:
- IMG_W, 160, pixels per line
- IMG_H, 120, lines per frame
- MIN_PIXELS, 64, minimum mask count for obj_found=1

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-low reset
- object_image  input  1  mask bit for current pixel
- pixel_valid  input  1  object_image valid this cycle
- frame_start  input  1  qualifies first pixel (0,0) of a frame; ignored unless pixel_valid=1
- out_ready  input  1  consumer accepts result
- out_valid  output  1  result valid
- obj_found  output  1  pix_count >= MIN_PIXELS
- pix_count  output  15  mask pixels in frame
- cent_x  output  8  centroid column
- cent_y  output  7  centroid row
- bbox_xmin, bbox_xmax  output  8 each  bounding box columns
- bbox_ymin, bbox_ymax  output  7 each  bounding box rows
- overrun  output  1  sticky: a finished frame was dropped
- frame_error  output  1  sticky: frame_start seen mid-frame

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM in IDLE; x/y counters, accumulators and stickies cleared. Reset mid-divide aborts the divide; no result is emitted.
- FSM states: IDLE, ACCUM, DIVIDE, HOLD.
- Accumulation runs in a separate path that is independent of FSM output states.
- Pixel tracking:
  - Pixels before the first frame_start are ignored.
  - frame_start&pixel_valid sets (x,y)=(0,0) and clears the accumulators, which then load this pixel.
  - Each subsequent valid pixel advances x. x wraps at IMG_W-1, incrementing y.
- Per valid pixel with object_image=1:
  - count+=1, sum_x+=x, sum_y+=y (22-bit sums).
  - min/max x and y updated; min initialised to all-ones, max to 0.
- Last pixel (x=IMG_W-1, y=IMG_H-1):
  - Next cycle, totals are snapshotted into result registers and accumulation arms for the next frame_start.
  - FSM goes to DIVIDE.
- DIVIDE:
  - Shared serial restoring divider, 22 cycles for sum_x/count, then 22 cycles for sum_y/count.
  - Results are floor quotients.
  - If count < MIN_PIXELS or count=0: divider skipped, obj_found=0, cent and bbox=0, pix_count still reported.
- out_valid: rises exactly 46 cycles after the edge that sampled the last pixel (1 snapshot + 44 divide + 1 load); 2 cycles when the divide is skipped.
- HOLD:
  - out_valid and all result outputs stay stable until out_valid&out_ready, then out_valid drops next cycle.
  - A new frame ending while in HOLD discards that frame's result; overrun=1; the held result is unchanged.
- frame_start mid-frame (position != last+1): partial frame discarded, frame_error=1, new frame starts at this pixel.
- Stickies clear only on reset.
- pixel_valid=0 cycles stall counters; no timeout.

Optional Feature:
- Macro: MASK_CENTROID_BBOX_EN.
- Defined: min/max trackers are built and bbox outputs are live.
- Undefined: trackers are absent and all four bbox outputs are tied 0.
- Centroid, count and handshake are identical in both builds.

Decomposition:
- Package mask_stats_pkg holds:
  - IMG_W/IMG_H defaults
  - derived widths: X_W=8, Y_W=7, CNT_W=15, SUM_W=22
  - FSM state encoding
- One sub-module: serial_divider (SUM_W/CNT_W, start/busy/done, floor quotient), reused for X then Y.

Test Plan:
- All-zero frame → out_valid at +2 cycles, obj_found=0, pix_count=0, cent/bbox=0.
- Rectangle x40..59, y30..49 (400 px) → pix_count=400, cent=(49,39), bbox=(40,59,30,49), out_valid at +46.
- Full frame of ones → pix_count=19200, cent=(79,59), bbox=(0,159,0,119).
- out_ready=0 across two full frames → first frame's result held unchanged, overrun=1, second result never shown.
- frame_start after 500 pixels of a 100%-ones frame, then a clean frame with a single 64-pixel block → frame_error=1, result reflects only the clean frame.
- rst low 20 cycles into DIVIDE → all outputs 0 immediately, no out_valid until the next complete frame; repeat without MASK_CENTROID_BBOX_EN → bbox ports always 0.

Source files
------------

// File: rtl/mask_stats_pkg.sv
// Shared constants and types for the mask centroid block.
//   DEF_IMG_W / DEF_IMG_H / DEF_MIN_PIXELS : default frame geometry and
//                                            object-present threshold
//   X_W, Y_W, CNT_W, SUM_W                 : coordinate, count and sum widths
//   state_t                                : result-side FSM encoding
package mask_stats_pkg;

  localparam int DEF_IMG_W      = 160;
  localparam int DEF_IMG_H      = 120;
  localparam int DEF_MIN_PIXELS = 64;

  localparam int X_W   = 8;   // column 0..159
  localparam int Y_W   = 7;   // row 0..119
  localparam int CNT_W = 15;  // up to 19200 mask pixels
  localparam int SUM_W = 22;  // sum of up to 19200 columns (< 2^22)

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no frame in progress, no result pending
    ACCUM  = 2'd1,  // frame in progress
    DIVIDE = 2'd2,  // centroid division running on the snapshot
    HOLD   = 2'd3   // result presented, waiting for out_ready
  } state_t;

endpackage

// File: rtl/serial_divider.sv
// Serial restoring divider, one quotient bit per clock, floor quotient.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start      : load dividend/divisor (ignored while busy); the first
//                quotient bit is produced on the start edge itself
//   dividend   : N_W-bit numerator, divisor : D_W-bit denominator (non-zero)
//   busy       : iterations in progress
//   done       : one-cycle pulse once all N_W bits are resolved; quotient
//                stays valid until the next start
//   quotient   : low Q_W bits of the floor quotient
module serial_divider
  import mask_stats_pkg::*;
#(
  parameter int N_W = SUM_W,
  parameter int D_W = CNT_W,
  parameter int Q_W = X_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int S_W = $clog2(N_W);

  logic [D_W-1:0] rem_q, rem_in, rem_nx;
  logic [N_W-1:0] quo_q, quo_in, quo_nx;
  logic [S_W-1:0] step_q;
  logic [D_W:0]   trial;
  logic           fits;
  logic           load;

  assign load = start & ~busy;

  // One restoring step; on a start edge it runs on the fresh operands so
  // that N_W edges in total resolve the quotient.
  always_comb begin
    rem_in = load ? '0 : rem_q;
    quo_in = load ? dividend : quo_q;
    trial  = {rem_in, quo_in[N_W-1]};
    fits   = (trial >= {1'b0, divisor});
    // The remainder is always below the divisor, so D_W bits suffice.
    rem_nx = fits ? (trial[D_W-1:0] - divisor) : trial[D_W-1:0];
    quo_nx = {quo_in[N_W-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        step_q <= S_W'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        step_q <= step_q + S_W'(1);
        if (step_q == S_W'(N_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[Q_W-1:0];

endmodule

// File: rtl/mask_centroid.sv
// Per-frame statistics of a 1-bit object mask in raster order: pixel count,
// centroid (floor of coordinate sums / count) and bounding box, presented
// once per frame on a valid/ready handshake.
// Build option: define MASK_CENTROID_BBOX_EN to build the min/max trackers;
// without it the four bbox outputs are tied to 0.
// Ports:
//   clk, rst                : pixel clock, asynchronous active-low reset
//   object_image            : mask bit of the current pixel
//   pixel_valid             : object_image valid this cycle (0 = stall)
//   frame_start             : pixel is (0,0) of a new frame (with pixel_valid)
//   out_ready / out_valid   : result handshake
//   obj_found, pix_count    : count >= MIN_PIXELS, mask pixel count
//   cent_x, cent_y          : centroid column / row
//   bbox_xmin..bbox_ymax    : bounding box
//   overrun, frame_error    : sticky drop / mid-frame frame_start flags
//   dbg_state               : current FSM state (state_t encoding)
// Handshake: a result transfers on any edge where out_valid & out_ready are
// both 1; out_valid and all result outputs are stable from rise until that
// edge, and out_valid drops right after it.
module mask_centroid
  import mask_stats_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int MIN_PIXELS = DEF_MIN_PIXELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             object_image,
  input  logic             pixel_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             obj_found,
  output logic [CNT_W-1:0] pix_count,
  output logic [X_W-1:0]   cent_x,
  output logic [Y_W-1:0]   cent_y,
  output logic [X_W-1:0]   bbox_xmin,
  output logic [X_W-1:0]   bbox_xmax,
  output logic [Y_W-1:0]   bbox_ymin,
  output logic [Y_W-1:0]   bbox_ymax,
  output logic             overrun,
  output logic             frame_error,
  output logic [1:0]       dbg_state
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  // ---------------------------------------------------------------------
  // Accumulation path: runs regardless of what the result side is doing.
  // ---------------------------------------------------------------------
  logic [X_W-1:0]   x_pos;      // position of the next expected pixel
  logic [Y_W-1:0]   y_pos;
  logic             in_frame;
  logic             frame_done; // registered pulse: last pixel sampled
  logic [CNT_W-1:0] acc_count;
  logic [SUM_W-1:0] acc_sum_x, acc_sum_y;

  logic             take_first, take_next, take_pixel, is_last;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] sx_base, sy_base;

  assign take_first = pixel_valid & frame_start;
  assign take_next  = pixel_valid & ~frame_start & in_frame;
  assign take_pixel = take_first | take_next;
  assign pix_x      = take_first ? '0 : x_pos;
  assign pix_y      = take_first ? '0 : y_pos;
  assign is_last    = (pix_x == X_LAST) && (pix_y == Y_LAST);
  // A frame_start pixel restarts the totals and is then accumulated itself.
  assign cnt_base   = take_first ? '0 : acc_count;
  assign sx_base    = take_first ? '0 : acc_sum_x;
  assign sy_base    = take_first ? '0 : acc_sum_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_pos       <= '0;
      y_pos       <= '0;
      in_frame    <= 1'b0;
      frame_done  <= 1'b0;
      acc_count   <= '0;
      acc_sum_x   <= '0;
      acc_sum_y   <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (take_pixel) begin
        acc_count <= cnt_base + CNT_W'(object_image);
        acc_sum_x <= sx_base + (object_image ? SUM_W'(pix_x) : '0);
        acc_sum_y <= sy_base + (object_image ? SUM_W'(pix_y) : '0);
        if (take_first && in_frame) frame_error <= 1'b1;
        if (is_last) begin
          // Disarm: further pixels are ignored until the next frame_start.
          in_frame   <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          in_frame <= 1'b1;
          if (pix_x == X_LAST) begin
            x_pos <= '0;
            y_pos <= pix_y + Y_W'(1);
          end else begin
            x_pos <= pix_x + X_W'(1);
            y_pos <= pix_y;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result side FSM
  // ---------------------------------------------------------------------
  state_t           state, state_nx;
  logic             snap_en, load, div_start;
  logic             snap_skip;
  logic [CNT_W-1:0] snap_count;
  logic [SUM_W-1:0] snap_sum_x, snap_sum_y, div_dividend;
  logic             div_go;   // X division has been launched
  logic             div_sel;  // 0: X division in flight, 1: Y division
  logic             div_busy, div_done;
  logic [X_W-1:0]   div_quo, quo_x;

  always_comb begin
    state_nx     = state;
    snap_en      = 1'b0;
    load         = 1'b0;
    div_start    = 1'b0;
    div_dividend = snap_sum_x;
    case (state)
      IDLE, ACCUM: begin
        if (frame_done) begin
          snap_en  = 1'b1;
          state_nx = DIVIDE;
        end else begin
          state_nx = in_frame ? ACCUM : IDLE;
        end
      end
      DIVIDE: begin
        if (snap_skip) begin
          load     = 1'b1;
          state_nx = HOLD;
        end else if (!div_go && !div_busy) begin
          div_start = 1'b1;
        end else if (div_done && !div_sel) begin
          div_start    = 1'b1;
          div_dividend = snap_sum_y;
        end else if (div_done && div_sel) begin
          load     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nx = in_frame ? ACCUM : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      snap_skip  <= 1'b0;
      snap_count <= '0;
      snap_sum_x <= '0;
      snap_sum_y <= '0;
      div_go     <= 1'b0;
      div_sel    <= 1'b0;
      quo_x      <= '0;
      obj_found  <= 1'b0;
      pix_count  <= '0;
      cent_x     <= '0;
      cent_y     <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nx;
      // A frame finishing while a result is still being produced or held
      // is dropped; the pending result is left untouched.
      if (frame_done && (state == DIVIDE || state == HOLD)) overrun <= 1'b1;
      if (snap_en) begin
        snap_count <= acc_count;
        snap_sum_x <= acc_sum_x;
        snap_sum_y <= acc_sum_y;
        snap_skip  <= (acc_count == '0) || (acc_count < CNT_W'(MIN_PIXELS));
        div_go     <= 1'b0;
        div_sel    <= 1'b0;
      end
      if (div_start) begin
        div_go <= 1'b1;
        if (div_go) div_sel <= 1'b1;
      end
      if (div_done && !div_sel) quo_x <= div_quo;
      if (load) begin
        obj_found <= ~snap_skip;
        pix_count <= snap_count;
        cent_x    <= snap_skip ? '0 : quo_x;
        cent_y    <= snap_skip ? '0 : div_quo[Y_W-1:0];
      end
    end
  end

  serial_divider #(
    .N_W (SUM_W),
    .D_W (CNT_W),
    .Q_W (X_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_count),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Bounding box trackers
  // ---------------------------------------------------------------------
`ifdef MASK_CENTROID_BBOX_EN
  logic [X_W-1:0] acc_xmin, acc_xmax, snap_xmin, snap_xmax, xmin_base, xmax_base;
  logic [Y_W-1:0] acc_ymin, acc_ymax, snap_ymin, snap_ymax, ymin_base, ymax_base;

  assign xmin_base = take_first ? '1 : acc_xmin;
  assign xmax_base = take_first ? '0 : acc_xmax;
  assign ymin_base = take_first ? '1 : acc_ymin;
  assign ymax_base = take_first ? '0 : acc_ymax;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_xmin  <= '1;
      acc_xmax  <= '0;
      acc_ymin  <= '1;
      acc_ymax  <= '0;
      snap_xmin <= '0;
      snap_xmax <= '0;
      snap_ymin <= '0;
      snap_ymax <= '0;
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
    end else begin
      if (take_pixel) begin
        acc_xmin <= (object_image && pix_x < xmin_base) ? pix_x : xmin_base;
        acc_xmax <= (object_image && pix_x > xmax_base) ? pix_x : xmax_base;
        acc_ymin <= (object_image && pix_y < ymin_base) ? pix_y : ymin_base;
        acc_ymax <= (object_image && pix_y > ymax_base) ? pix_y : ymax_base;
      end
      if (snap_en) begin
        snap_xmin <= acc_xmin;
        snap_xmax <= acc_xmax;
        snap_ymin <= acc_ymin;
        snap_ymax <= acc_ymax;
      end
      if (load) begin
        bbox_xmin <= snap_skip ? '0 : snap_xmin;
        bbox_xmax <= snap_skip ? '0 : snap_xmax;
        bbox_ymin <= snap_skip ? '0 : snap_ymin;
        bbox_ymax <= snap_skip ? '0 : snap_ymax;
      end
    end
  end
`else
  assign bbox_xmin = '0;
  assign bbox_xmax = '0;
  assign bbox_ymin = '0;
  assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Self-checking bench for mask_centroid. Frames are painted into an image
// array; the reference model derives count, centroid and box from the whole
// image with plain arithmetic. Follows the MASK_CENTROID_BBOX_EN define.
`timescale 1ns/1ps
module tb_mask_centroid;
  import mask_stats_pkg::*;

  localparam int W    = DEF_IMG_W;
  localparam int H    = DEF_IMG_H;
  localparam int MINP = DEF_MIN_PIXELS;

  typedef struct packed {
    logic        found;
    logic [14:0] count;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic [7:0]  xmin;
    logic [7:0]  xmax;
    logic [6:0]  ymin;
    logic [6:0]  ymax;
  } res_t;
  localparam int RES_W = $bits(res_t);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        object_image = 1'b0, pixel_valid = 1'b0, frame_start = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, obj_found, overrun, frame_error;
  logic [14:0] pix_count;
  logic [7:0]  cent_x, bbox_xmin, bbox_xmax;
  logic [6:0]  cent_y, bbox_ymin, bbox_ymax;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mask_centroid dut (
    .clk          (clk),
    .rst          (rst),
    .object_image (object_image),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .obj_found    (obj_found),
    .pix_count    (pix_count),
    .cent_x       (cent_x),
    .cent_y       (cent_y),
    .bbox_xmin    (bbox_xmin),
    .bbox_xmax    (bbox_xmax),
    .bbox_ymin    (bbox_ymin),
    .bbox_ymax    (bbox_ymax),
    .overrun      (overrun),
    .frame_error  (frame_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RES_W-1:0] exp_q[$];
  bit img [H][W];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: statistics over the painted image, straight from the rules.
  function automatic res_t model_frame();
    res_t r;
    int cnt, sx, sy, xmin, xmax, ymin, ymax;
    r = '0; cnt = 0; sx = 0; sy = 0;
    xmin = W; xmax = 0; ymin = H; ymax = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (img[y][x]) begin
          cnt++; sx += x; sy += y;
          if (x < xmin) xmin = x;
          if (x > xmax) xmax = x;
          if (y < ymin) ymin = y;
          if (y > ymax) ymax = y;
        end
    r.count = 15'(cnt);
    if (cnt >= MINP) begin
      r.found = 1'b1;
      r.cx    = 8'(sx / cnt);
      r.cy    = 7'(sy / cnt);
`ifdef MASK_CENTROID_BBOX_EN
      r.xmin  = 8'(xmin);
      r.xmax  = 8'(xmax);
      r.ymin  = 7'(ymin);
      r.ymax  = 7'(ymax);
`endif
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag, input res_t e);
    check_val({tag, "_found"}, obj_found, e.found);
    check_val({tag, "_count"}, pix_count, e.count);
    check_val({tag, "_cx"},    cent_x,    e.cx);
    check_val({tag, "_cy"},    cent_y,    e.cy);
    check_val({tag, "_xmin"},  bbox_xmin, e.xmin);
    check_val({tag, "_xmax"},  bbox_xmax, e.xmax);
    check_val({tag, "_ymin"},  bbox_ymin, e.ymin);
    check_val({tag, "_ymax"},  bbox_ymax, e.ymax);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_px(input logic v, input logic fs, input logic b);
    pixel_valid  = v;
    frame_start  = fs;
    object_image = b;
    @(posedge clk); #1;
    pixel_valid  = 1'b0;
    frame_start  = 1'b0;
    object_image = 1'b0;
  endtask

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  // Drives img as one frame; stall cycles carry random junk, including
  // frame_start, which must be ignored without pixel_valid.
  task automatic drive_frame(input int stall_pct);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if ($urandom_range(0, 99) < stall_pct)
          drive_px(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive_px(1'b1, (x == 0 && y == 0), img[y][x]);
      end
  endtask

  // Edges from the last pixel until out_valid is seen; -1 if never.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pop_and_check(input string tag);
    res_t e;
    e = res_t'(exp_q.pop_front());
    check_outputs(tag, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   lat, seen, n, x0, y0;
    res_t held;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_state", dbg_state, IDLE);
    check_outputs("rst", '0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_ferr", frame_error, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Frame 1: junk before any frame_start, a 500-pixel aborted frame,
    // then the 20x20 rectangle at x40..59, y30..49.
    repeat (50) drive_px(1'b1, 1'b0, 1'b1);
    drive_px(1'b1, 1'b1, 1'b1);
    repeat (499) drive_px(1'b1, 1'b0, 1'b1);
    clear_img();
    for (int y = 30; y <= 49; y++)
      for (int x = 40; x <= 59; x++) img[y][x] = 1'b1;
    exp_q.push_back(model_frame());
    drive_frame(0);
    wait_valid(lat);
    check_val("rect_latency", lat, 46);
    pop_and_check("rect");
    check_val("rect_ferr", frame_error, 1);
    check_val("rect_overrun", overrun, 0);
    @(posedge clk); #1;
    check_val("rect_valid_drop", out_valid, 0);

    // Frame 2: sparse random mask below threshold, held with out_ready=0.
    out_ready = 1'b0;
    clear_img();
    n = $urandom_range(1, MINP - 1);
    for (int i = 0; i < n; i++) img[$urandom_range(0, H-1)][$urandom_range(0, W-1)] = 1'b1;
    held = model_frame();
    exp_q.push_back(held);
    drive_frame(5);
    wait_valid(lat);
    check_val("sparse_latency", lat, 2);
    pop_and_check("sparse");

    // Frame 3: all ones, ends while frame 2 is held -> dropped.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b1;
    drive_frame(0);
    repeat (60) @(posedge clk);
    #1;
    check_val("hold_valid", out_valid, 1);
    check_outputs("hold", held);
    check_val("hold_overrun", overrun, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("hold_valid_drop", out_valid, 0);
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("dropped_not_shown", seen, 0);

    // Frame 4: random dense mask, reset 20 cycles into the divide.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'($urandom_range(0, 1));
    x0 = $urandom_range(0, W - 8);
    y0 = $urandom_range(0, H - 8);
    for (int y = y0; y < y0 + 8; y++)
      for (int x = x0; x < x0 + 8; x++) img[y][x] = 1'b1;
    drive_frame(0);
    repeat (21) @(posedge clk);
    #1;
    check_val("pre_rst_state", dbg_state, DIVIDE);
    rst = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_outputs("mid_rst", '0);
    check_val("mid_rst_overrun", overrun, 0);
    check_val("mid_rst_ferr", frame_error, 0);
    check_val("mid_rst_state", dbg_state, IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) drive_px(1'b1, 1'b0, 1'b1);
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("post_rst_no_valid", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
